uart_rx_core: RTL and testbench



---
 rtl/uart_rx_core_pkg.sv | 5 +
 rtl/uart_baud_tick.sv | 16 +
 rtl/uart_rx_core.sv | 82 ++++++++
 tb/tb_uart_rx_core.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_core_pkg.sv
// uart_rx_core_pkg: receiver FSM states and oversampling rate shared by the UART receive path
package uart_rx_core_pkg;
   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
   localparam int OVERSAMPLE = 16;
endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: free-running divider producing a one-cycle oversampling tick every final_value+1 clocks
module uart_baud_tick #(
   parameter int BAUD_W = 9
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [BAUD_W-1:0] final_value,
   output logic              tick
);
   logic [BAUD_W-1:0] cnt;
   assign tick = cnt == final_value;
   // a count left above a lowered final_value simply wraps through its maximum
   always_ff @(posedge clk)
      if (reset) cnt <= '0;
      else cnt <= tick ? '0 : cnt + 1'b1;
endmodule

// File: rtl/uart_rx_core.sv
// uart_rx_core: 16x-oversampling UART receiver with its own baud-tick generator
module uart_rx_core
   import uart_rx_core_pkg::*;
#(
   parameter int DBIT    = 8,
   parameter int SB_TICK = 16,
   parameter int BAUD_W  = 9
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [BAUD_W-1:0] final_value,
   input  logic              rx,
   output logic              s_tick,
   output logic              rx_done_tick,
   output logic [DBIT-1:0]   rx_out,
   output logic              frame_err
);
   localparam int NW = DBIT > 1 ? $clog2(DBIT) : 1;
   // wide enough for stop-bit lengths beyond one bit time
   localparam int SW = SB_TICK > OVERSAMPLE ? $clog2(SB_TICK) : $clog2(OVERSAMPLE);
   state_t          state;
   logic [SW-1:0]   s;
   logic [NW-1:0]   n;
   logic [DBIT-1:0] b;
   logic [1:0]      sync;
   logic            rx_s;
   uart_baud_tick #(.BAUD_W(BAUD_W)) u_baud (
      .clk(clk),
      .reset(reset),
      .final_value(final_value),
      .tick(s_tick)
   );
   assign rx_s = sync[1];
   always_ff @(posedge clk)
      if (reset) sync <= 2'b11;
      else sync <= {sync[0], rx};
   always_ff @(posedge clk)
      if (reset) begin
         state        <= IDLE;
         s            <= '0;
         n            <= '0;
         b            <= '0;
         rx_out       <= '0;
         frame_err    <= 1'b0;
         rx_done_tick <= 1'b0;
      end else begin
         rx_done_tick <= 1'b0;
         case (state)
            IDLE:
               if (!rx_s) begin
                  state <= START;
                  s     <= '0;
               end
            START:
               if (s_tick) begin
                  if (s == SW'(OVERSAMPLE/2-1)) begin
                     state <= rx_s ? IDLE : DATA;
                     s     <= '0;
                     n     <= '0;
                  end else s <= s + 1'b1;
               end
            DATA:
               if (s_tick) begin
                  if (s == SW'(OVERSAMPLE-1)) begin
                     s <= '0;
                     b <= {rx_s, b[DBIT-1:1]};
                     if (n == NW'(DBIT-1)) state <= STOP;
                     else n <= n + 1'b1;
                  end else s <= s + 1'b1;
               end
            STOP:
               if (s_tick) begin
                  if (s == SW'(SB_TICK-1)) begin
                     state        <= IDLE;
                     rx_out       <= b;
                     frame_err    <= ~rx_s;
                     rx_done_tick <= 1'b1;
                  end else s <= s + 1'b1;
               end
         endcase
      end
endmodule

// File: tb/tb_uart_rx_core.sv
// tb_uart_rx_core: randomized frames against a frame-level model of the UART receiver
module tb_uart_rx_core;
   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       rx = 1'b1;
   logic [8:0] final_value = 9'd3;
   logic       s_tick, rx_done_tick, frame_err;
   logic [7:0] rx_out;

   uart_rx_core dut (
      .clk(clk),
      .reset(reset),
      .final_value(final_value),
      .rx(rx),
      .s_tick(s_tick),
      .rx_done_tick(rx_done_tick),
      .rx_out(rx_out),
      .frame_err(frame_err)
   );

   always #5 clk = ~clk;

   int cyc = 0, rel = 0;
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (reset) rel <= cyc + 1;
   end

   typedef struct {logic [7:0] d; logic fe; int t0;} exp_t;
   exp_t q[$];
   int errors = 0, checks = 0, ndone = 0;
   logic [7:0] exp_out = '0;
   logic       exp_fe = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, req, cyc);
      end
   endtask

   // frame-level model: each pushed frame must come out once, in order, ~152 ticks after its start edge
   initial forever begin
      exp_t e;
      int p, d;
      @(negedge clk);
      p = int'(final_value) + 1;
      if (rel == cyc) begin
         q.delete();
         exp_out = '0;
         exp_fe = 1'b0;
         chk("done_in_reset", {31'd0, rx_done_tick}, 0);
      end else if (rx_done_tick) begin
         ndone++;
         if (q.size() == 0) chk("unexpected_done", 1, 0);
         else begin
            e = q.pop_front();
            exp_out = e.d;
            exp_fe = e.fe;
            d = cyc - e.t0;
            chk("done_latency_ok", {31'd0, d >= 151*p && d <= 152*p + 6}, 1);
         end
      end
      chk("rx_out", {24'd0, rx_out}, {24'd0, exp_out});
      chk("frame_err", {31'd0, frame_err}, {31'd0, exp_fe});
      chk("s_tick", {31'd0, s_tick}, {31'd0, ((cyc - rel) % p) == p - 1});
   end

   task automatic wait_ticks(input int t);
      repeat (t * (int'(final_value) + 1)) @(negedge clk);
   endtask

   task automatic do_reset(input logic [8:0] fv);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      final_value = fv;
      repeat (3) @(negedge clk);
      reset = 1'b0;
   endtask

   // a bad stop bit is held low only 10 ticks so the re-armed start detect rejects it as a glitch
   task automatic send(input logic [7:0] d, input bit stop_ok, input int gap);
      exp_t e;
      e.d = d;
      e.fe = !stop_ok;
      e.t0 = cyc;
      q.push_back(e);
      rx = 1'b0;
      wait_ticks(16);
      for (int i = 0; i < 8; i++) begin
         rx = d[i];
         wait_ticks(16);
      end
      rx = stop_ok;
      wait_ticks(stop_ok ? 16 : 10);
      rx = 1'b1;
      wait_ticks(gap);
   endtask

   initial begin
      int nd0, cnt;
      do_reset(9'd324);
      chk("reset_rx_out", {24'd0, rx_out}, 0);
      chk("reset_done", {31'd0, rx_done_tick}, 0);
      chk("reset_ferr", {31'd0, frame_err}, 0);
      chk("reset_s_tick", {31'd0, s_tick}, 0);
      cnt = 0;
      repeat (1300) begin
         @(negedge clk);
         cnt += int'(s_tick);
      end
      chk("tick_count_1300", cnt, 4);
      chk("idle_no_done", ndone, 0);

      do_reset(9'd49);
      send(8'h4B, 1'b1, 16);
      chk("byte_4b", {24'd0, rx_out}, 32'h4B);
      chk("byte_4b_ferr", {31'd0, frame_err}, 0);
      chk("byte_4b_done", ndone, 1);
      wait_ticks(32);
      chk("byte_4b_held", {24'd0, rx_out}, 32'h4B);

      do_reset(9'd3);
      send(8'h11, 1'b1, 16);
      nd0 = ndone;
      rx = 1'b0;
      wait_ticks(3);
      rx = 1'b1;
      wait_ticks(24);
      chk("glitch_no_done", ndone, nd0);
      chk("glitch_rx_out", {24'd0, rx_out}, 32'h11);
      send(8'hA5, 1'b0, 32);
      chk("ferr_byte", {24'd0, rx_out}, 32'hA5);
      chk("ferr_flag", {31'd0, frame_err}, 1);
      chk("ferr_one_done", ndone, nd0 + 1);
      send(8'h3C, 1'b1, 16);
      chk("clean_byte", {24'd0, rx_out}, 32'h3C);
      chk("clean_ferr", {31'd0, frame_err}, 0);
      nd0 = ndone;
      send(8'h00, 1'b1, 0);
      chk("b2b_first", {24'd0, rx_out}, 32'h00);
      send(8'hFF, 1'b1, 16);
      chk("b2b_second", {24'd0, rx_out}, 32'hFF);
      chk("b2b_done_count", ndone, nd0 + 2);

      nd0 = ndone;
      rx = 1'b0;
      wait_ticks(16);
      for (int i = 0; i < 4; i++) begin
         rx = i[0];
         wait_ticks(16);
      end
      wait_ticks(8);
      reset = 1'b1;
      repeat (3) @(negedge clk);
      rx = 1'b1;
      reset = 1'b0;
      wait_ticks(200);
      chk("abort_no_done", ndone, nd0);
      chk("abort_rx_out", {24'd0, rx_out}, 0);
      chk("abort_ferr", {31'd0, frame_err}, 0);
      send(8'h5A, 1'b1, 16);
      chk("after_abort", {24'd0, rx_out}, 32'h5A);

      do_reset(9'($urandom_range(3, 6)));
      for (int k = 0; k < 25; k++) begin
         if ($urandom_range(0, 7) == 0) begin
            rx = 1'b0;
            wait_ticks($urandom_range(1, 5));
            rx = 1'b1;
            wait_ticks(16);
         end else if ($urandom_range(0, 5) == 0)
            send(8'($urandom), 1'b0, 16 + $urandom_range(0, 15));
         else
            send(8'($urandom), 1'b1, 8 * $urandom_range(0, 2));
      end
      wait_ticks(40);
      chk("all_frames_delivered", q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
